// File: rtl/aes_pkg.sv
// aes_pkg: constants, FSM encoding, S-boxes and GF(2^8) helpers
// shared by the iterative AES-128 datapaths.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        DONE
    } fsm_e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row 0 of the column sits in the most significant byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {
            mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
            mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
            mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
            mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)
        };
    endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// aes_decrypt_iter_if: ciphertext/key request and plaintext response
// handshakes of the iterative AES-128 decryptor.
interface aes_decrypt_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext, busy
    );

endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round
// (InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] state_out
);

    logic [127:0] ark;

    // Row r of output column c comes from input column (c - r) mod 4.
    always_comb begin
        ark = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                ark[127-32*c-8*r -: 8] =
                    inv_sbox(state_in[127-32*((c+4-r)%4)-8*r -: 8]) ^
                    round_key[127-32*c-8*r -: 8];
    end

    always_comb begin
        state_out = ark;
        if (!final_round)
            for (int c = 0; c < 4; c++)
                state_out[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

endmodule

// File: rtl/key_expansion.sv
// key_expansion: combinational AES-128 key schedule; round n key
// is presented at round_keys[128*n +: 128].
module key_expansion
    import aes_pkg::*;
(
    input  logic [127:0]              key,
    output logic [128*(AES_NR+1)-1:0] round_keys
);

    function automatic logic [128*(AES_NR+1)-1:0] expand(input logic [127:0] k);
        logic [31:0] w [4*(AES_NR+1)];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [128*(AES_NR+1)-1:0] r;
        rcon = 8'h01;
        r    = '0;
        for (int i = 0; i < 4; i++)
            w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 4*(AES_NR+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                // RotWord then SubWord, then fold in the round constant
                t = {sbox(t[23:16]), sbox(t[15:8]),
                     sbox(t[7:0]),   sbox(t[31:24])} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n <= AES_NR; n++)
            r[128*n +: 128] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        return r;
    endfunction

    assign round_keys = expand(key);

endmodule

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 inverse cipher, one inverse
// round per clock, valid/ready on both request and response.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic               clk,
    input  logic               rst_n,
    aes_decrypt_iter_if.slave  bus
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_decrypt_iter: only NR=10 (AES-128) is supported");
    end

    fsm_e         fsm;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [3:0]   rnd;
    logic [127:0] rk;
    logic [127:0] round_out;
    logic [128*(AES_NR+1)-1:0] rk_all;

    key_expansion u_kexp (
        .key        (key_reg),
        .round_keys (rk_all)
    );

    // rnd holds 10 during INIT so the same mux serves every step.
    assign rk = rk_all[128*rnd +: 128];

    aes_inv_round u_round (
        .state_in    (state_reg),
        .round_key   (rk),
        .final_round (rnd == 4'd0),
        .state_out   (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm           <= IDLE;
            state_reg     <= '0;
            key_reg       <= '0;
            rnd           <= '0;
            bus.plaintext <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg    <= bus.ciphertext;
                        key_reg      <= bus.key;
                        rnd          <= 4'(AES_NR);
                        fsm          <= INIT;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                INIT: begin
                    state_reg <= state_reg ^ rk;
                    rnd       <= 4'(AES_NR - 1);
                    fsm       <= ROUND;
                end
                ROUND: begin
                    if (rnd == 4'd0) begin
                        bus.plaintext <= round_out;
                        bus.out_valid <= 1'b1;
                        fsm           <= DONE;
                    end else begin
                        state_reg <= round_out;
                        rnd       <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        fsm           <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb_aes_decrypt_iter: known-answer vectors, handshake corner cases
// and random round-trips against a FIPS-197 forward-cipher model.
module tb_aes_decrypt_iter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_decrypt_iter_if bus ();

    aes_decrypt_iter #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           acc_q[$];
    int           out_q[$];
    logic [127:0] pt_q[$];
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
            if (bus.out_valid && bus.out_ready) begin
                out_q.push_back(cyc);
                pt_q.push_back(bus.plaintext);
            end
        end
    end

    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] mk_keys(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        logic [1407:0] r = '0;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 11; n++)
            r[128*n +: 128] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        return r;
    endfunction

    // Forward cipher; byte i of a block is column i/4, row i%4.
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [1407:0] ks = mk_keys(k);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[127-8*i -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sb[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= ks[128*rd + 127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered on a negedge; returns on the negedge where out_valid is
    // first seen, with lat = posedges after the accepting edge.
    task automatic launch(input logic [127:0] k, input logic [127:0] ct, output int lat);
        int n = 0;
        bus.key = k;
        bus.ciphertext = ct;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.key = rnd128();
        bus.ciphertext = rnd128();
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [127:0] k;
        logic [127:0] p;

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a};

        build_sbox();

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.key = '0;
        bus.ciphertext = '0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
        chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
        chk("reset_plaintext", bus.plaintext, 128'd0);
        chk("reset_busy", 128'(bus.busy), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 128'(bus.in_ready), 128'd1);

        foreach (vecs[i]) begin
            launch(vecs[i].key, vecs[i].ct, lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'd11);
            chk($sformatf("vec%0d_plaintext", i), bus.plaintext, vecs[i].pt);
            chk($sformatf("vec%0d_busy", i), 128'(bus.busy), 128'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_idle", i),
                128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));
        end

        bus.out_ready = 1'b0;
        launch(vecs[0].key, vecs[0].ct, lat);
        chk("bp_latency", 128'(lat), 128'd11);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                bus.in_valid = 1'b1;
                bus.key = vecs[1].key;
                bus.ciphertext = vecs[1].ct;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("bp_hold_flags_%0d", i),
                128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b101));
            chk($sformatf("bp_hold_pt_%0d", i), bus.plaintext, vecs[0].pt);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_flags",
            128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b010));
        chk("bp_release_pt_kept", bus.plaintext, vecs[0].pt);
        repeat (3) @(negedge clk);
        chk("bp_pulse_ignored", 128'({bus.out_valid, bus.busy}), 128'd0);

        acc_q.delete();
        out_q.delete();
        pt_q.delete();
        bus.key = vecs[0].key;
        bus.ciphertext = vecs[0].ct;
        bus.in_valid = 1'b1;
        n = 0;
        while (acc_q.size() < 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        bus.key = vecs[1].key;
        bus.ciphertext = vecs[1].ct;
        n = 0;
        while (acc_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        n = 0;
        while (out_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_counts", 128'({acc_q.size(), out_q.size()}), {96'd0, 32'd2, 32'd2} >> 0);
        if (acc_q.size() >= 2 && out_q.size() >= 2) begin
            chk("b2b_first_out_edge", 128'(out_q[0] - acc_q[0]), 128'd12);
            chk("b2b_second_accept", 128'(acc_q[1] - out_q[0]), 128'd1);
            chk("b2b_second_out_edge", 128'(out_q[1] - acc_q[1]), 128'd12);
            chk("b2b_pt0", pt_q[0], vecs[0].pt);
            chk("b2b_pt1", pt_q[1], vecs[1].pt);
        end
        @(negedge clk);

        bus.key = vecs[1].key;
        bus.ciphertext = vecs[1].ct;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags",
            128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b010));
        chk("rst_mid_pt", bus.plaintext, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_no_partial", 128'({bus.out_valid, bus.in_ready}), 128'(2'b01));
        launch(vecs[0].key, vecs[0].ct, lat);
        chk("rst_rerun_latency", 128'(lat), 128'd11);
        chk("rst_rerun_pt", bus.plaintext, vecs[0].pt);
        @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            k = rnd128();
            p = rnd128();
            launch(k, model_enc(p, k), lat);
            chk($sformatf("rt%0d_pt", i), bus.plaintext, p);
            if (lat != 11) chk($sformatf("rt%0d_latency", i), 128'(lat), 128'd11);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
